// File: rtl/adc_spi_master_pkg.sv
// Shared types and constants for the ADC SPI master: FSM states, SPI mode-0 levels
// and per-ADC transfer defaults.
package adc_spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

  // Mode 0: SCK idles low, data captured on the rising edge.
  localparam logic SPI_CPOL  = 1'b0;
  localparam logic SCK_IDLE  = SPI_CPOL;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int AD4030_DATA_WIDTH  = 24;
  localparam int AD4030_CLK_DIV     = 2;
  localparam int ADS8689_DATA_WIDTH = 32;
  localparam int ADS8689_CLK_DIV    = 4;
  localparam int DEFAULT_CS_SETUP   = 2;
  localparam int DEFAULT_CS_HOLD    = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_spi_sck_gen.sv
// SCK generator: CLK_DIV clocks per half-period while enabled, with strobes marking
// the clock on which SCK rises or falls. Parks SCK at its idle level when disabled.
module adc_spi_sck_gen
  import adc_spi_master_pkg::*;
#(
  parameter int CLK_DIV = AD4030_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DIV_W = cnt_width(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             half_end;

  assign half_end = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_stb = half_end && (sck == SCK_IDLE);
  assign fall_stb = half_end && (sck != SCK_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of the order in which always blocks execute.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt <= '0;
      sck     <= SCK_IDLE;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= SCK_IDLE;
    end else if (half_end) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Single-channel mode-0 SPI master for the ADC front ends: one fixed-length full-duplex
// transfer per start rising edge. Define ADC_SPI_XFER_CNT_EN to add the o_xfer_cnt debug counter.
module adc_spi_master
  import adc_spi_master_pkg::*;
#(
  parameter int DATA_WIDTH   = AD4030_DATA_WIDTH,
  parameter int CLK_DIV      = AD4030_CLK_DIV,
  parameter int CS_SETUP_CYC = DEFAULT_CS_SETUP,
  parameter int CS_HOLD_CYC  = DEFAULT_CS_HOLD
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_spi_cs_n,
  output logic                  o_spi_sck,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
`ifdef ADC_SPI_XFER_CNT_EN
  ,
  output logic [15:0]           o_xfer_cnt
`endif
);

  localparam int BIT_W   = cnt_width(DATA_WIDTH);
  localparam int PHASE_W = cnt_width(max2(CS_SETUP_CYC, CS_HOLD_CYC));

  spi_state_e            state;
  logic                  start_q;
  logic                  start_rise;
  logic [BIT_W-1:0]      bit_cnt;
  logic [PHASE_W-1:0]    phase_cnt;
  logic [DATA_WIDTH-2:0] tx_sr;      // bits still to send after the one on o_spi_mosi
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  sck_en;
  logic                  rise_stb;
  logic                  fall_stb;
  logic                  last_bit;

  assign start_rise = i_spi_start && !start_q;
  assign sck_en     = (state == SHIFT);
  assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  adc_spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .en      (sck_en),
    .sck     (o_spi_sck),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      bit_cnt      <= '0;
      phase_cnt    <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      o_miso_data  <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_spi_cs_n   <= 1'b1;
      o_spi_mosi   <= MOSI_IDLE;
    end else begin
      start_q      <= i_spi_start;
      o_data_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          // Edges arriving in any other state are simply ignored, never queued.
          if (start_rise) begin
            tx_sr      <= i_mosi_data[DATA_WIDTH-2:0];
            o_spi_mosi <= i_mosi_data[DATA_WIDTH-1];
            rx_sr      <= '0;
            bit_cnt    <= '0;
            phase_cnt  <= '0;
            o_busy     <= 1'b1;
            o_spi_cs_n <= 1'b0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (phase_cnt == PHASE_W'(CS_SETUP_CYC - 1)) begin
            phase_cnt <= '0;
            state     <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (rise_stb) begin
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], i_spi_miso};
          end
          if (fall_stb) begin
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              o_spi_mosi <= tx_sr[DATA_WIDTH-2];
              tx_sr      <= {tx_sr[DATA_WIDTH-3:0], 1'b0};
            end
          end
        end

        HOLD: begin
          if (phase_cnt == PHASE_W'(CS_HOLD_CYC - 1)) begin
            phase_cnt    <= '0;
            o_spi_cs_n   <= 1'b1;
            o_spi_mosi   <= MOSI_IDLE;
            o_data_valid <= 1'b1;
            o_miso_data  <= rx_sr;
            state        <= DONE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SPI_XFER_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_xfer_cnt <= '0;
    end else if (o_data_valid) begin
      o_xfer_cnt <= o_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: three instances (AD4030 default, ADS8689, CLK_DIV=1) each
// talking to a behavioural mode-0 slave; table, random and hand-written sequences.
`timescale 1ns/1ps
module tb_adc_spi_master;
  import adc_spi_master_pkg::*;

  localparam int SETUP_C = 2;
  localparam int HOLD_C  = 2;
  localparam int LIMIT   = 2000;

  logic clk = 1'b0;
  always #2.5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start;
  logic [31:0] mo_word  [3];
  logic [31:0] slv_word [3];

  wire  [2:0]  cs_n, sck, mosi_o, miso, valid, busy;
  wire  [23:0] rx0, rx2;
  wire  [31:0] rx1;
`ifdef ADC_SPI_XFER_CNT_EN
  wire  [15:0] xc0, xc1, xc2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt [3];
  int vcount [3];

  adc_spi_master #(
    .DATA_WIDTH(AD4030_DATA_WIDTH), .CLK_DIV(AD4030_CLK_DIV),
    .CS_SETUP_CYC(SETUP_C), .CS_HOLD_CYC(HOLD_C)
  ) u_dut_v (
    .i_clk(clk), .i_rst(rst_n), .i_spi_start(start[0]), .i_mosi_data(mo_word[0][23:0]),
    .o_miso_data(rx0), .o_data_valid(valid[0]), .o_busy(busy[0]), .o_spi_cs_n(cs_n[0]),
    .o_spi_sck(sck[0]), .o_spi_mosi(mosi_o[0]), .i_spi_miso(miso[0])
`ifdef ADC_SPI_XFER_CNT_EN
    , .o_xfer_cnt(xc0)
`endif
  );

  adc_spi_master #(
    .DATA_WIDTH(ADS8689_DATA_WIDTH), .CLK_DIV(ADS8689_CLK_DIV),
    .CS_SETUP_CYC(SETUP_C), .CS_HOLD_CYC(HOLD_C)
  ) u_dut_dc (
    .i_clk(clk), .i_rst(rst_n), .i_spi_start(start[1]), .i_mosi_data(mo_word[1]),
    .o_miso_data(rx1), .o_data_valid(valid[1]), .o_busy(busy[1]), .o_spi_cs_n(cs_n[1]),
    .o_spi_sck(sck[1]), .o_spi_mosi(mosi_o[1]), .i_spi_miso(miso[1])
`ifdef ADC_SPI_XFER_CNT_EN
    , .o_xfer_cnt(xc1)
`endif
  );

  adc_spi_master #(
    .DATA_WIDTH(24), .CLK_DIV(1),
    .CS_SETUP_CYC(SETUP_C), .CS_HOLD_CYC(HOLD_C)
  ) u_dut_fast (
    .i_clk(clk), .i_rst(rst_n), .i_spi_start(start[2]), .i_mosi_data(mo_word[2][23:0]),
    .o_miso_data(rx2), .o_data_valid(valid[2]), .o_busy(busy[2]), .o_spi_cs_n(cs_n[2]),
    .o_spi_sck(sck[2]), .o_spi_mosi(mosi_o[2]), .i_spi_miso(miso[2])
`ifdef ADC_SPI_XFER_CNT_EN
    , .o_xfer_cnt(xc2)
`endif
  );

  function automatic int dw_of(input int k);
    return (k == 1) ? 32 : 24;
  endfunction

  function automatic int div_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (dw_of(k) == 32) ? 32'hFFFF_FFFF : ((32'h1 << dw_of(k)) - 32'h1);
  endfunction

  function automatic int exp_lat(input int k);
    return 1 + SETUP_C + 2 * div_of(k) * dw_of(k) + HOLD_C;
  endfunction

  // Mode-0 slave: MSB out when CS falls, capture MOSI on SCK rise, next bit after SCK fall.
  for (genvar g = 0; g < 3; g++) begin : g_slave
    logic [31:0] sh    = '0;
    logic [31:0] cap   = '0;
    logic        miso_s = 1'b0;
    logic        cs_p  = 1'b1;
    logic        sck_p = 1'b0;
    assign miso[g] = miso_s;
    always @(cs_n[g] or sck[g]) begin
      if (cs_p && !cs_n[g]) begin
        sh     = slv_word[g] << (32 - dw_of(g));
        miso_s = sh[31];
        cap    = '0;
      end else if (!cs_n[g] && !sck_p && sck[g]) begin
        cap = {cap[30:0], mosi_o[g]};
      end else if (!cs_n[g] && sck_p && !sck[g]) begin
        sh     = sh << 1;
        miso_s = sh[31];
      end
      cs_p  = cs_n[g];
      sck_p = sck[g];
    end
  end

  function automatic logic [31:0] rx_of(input int k);
    case (k)
      0:       return {8'h0, rx0};
      1:       return rx1;
      default: return {8'h0, rx2};
    endcase
  endfunction

  function automatic logic [31:0] cap_of(input int k);
    case (k)
      0:       return g_slave[0].cap;
      1:       return g_slave[1].cap;
      default: return g_slave[2].cap;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (valid[i] === 1'b1) vcount[i]++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One transfer on instance k; start rises for cycle 0, outputs sampled each negedge.
  task automatic do_xfer(input int k, input logic [31:0] mo, input logic [31:0] sw);
    int   lat = 0, cs_low = 0, rises = 0, bad_mosi = 0, bad_gap = 0, busy_lo = 0, last_rise = 0;
    logic p_sck = 1'b0, p_cs = 1'b1, p_mosi;
    mo_word[k]  = mo;
    slv_word[k] = sw;
    @(negedge clk); start[k] = 1'b0;
    @(negedge clk); start[k] = 1'b1;
    p_mosi = mosi_o[k];
    for (int n = 1; n <= LIMIT && lat == 0; n++) begin
      @(negedge clk);
      if (!cs_n[k]) cs_low++;
      if (!busy[k]) busy_lo++;
      if (!p_sck && sck[k]) begin
        rises++;
        if (last_rise > 0 && (n - last_rise) != 2 * div_of(k)) bad_gap++;
        last_rise = n;
      end
      if (mosi_o[k] !== p_mosi && !p_cs && !cs_n[k] && !(p_sck && !sck[k])) bad_mosi++;
      if (valid[k]) lat = n;
      p_sck  = sck[k];
      p_cs   = cs_n[k];
      p_mosi = mosi_o[k];
    end
    @(negedge clk); start[k] = 1'b0;
    check($sformatf("k%0d_latency", k), lat, exp_lat(k));
    check($sformatf("k%0d_rx_word", k), rx_of(k), sw & mask_of(k));
    check($sformatf("k%0d_slave_mosi", k), cap_of(k) & mask_of(k), mo & mask_of(k));
    check($sformatf("k%0d_sck_rises", k), rises, dw_of(k));
    check($sformatf("k%0d_cs_low_cycles", k), cs_low, exp_lat(k) - 1);
    check($sformatf("k%0d_sck_period_errs", k), bad_gap, 0);
    check($sformatf("k%0d_mosi_timing_errs", k), bad_mosi, 0);
    check($sformatf("k%0d_busy_gaps", k), busy_lo, 0);
    check($sformatf("k%0d_valid_one_cycle", k), valid[k], 1'b0);
    check($sformatf("k%0d_busy_after_done", k), busy[k], 1'b0);
    check($sformatf("k%0d_cs_high_after", k), cs_n[k], 1'b1);
    model_cnt[k]++;
  endtask

  typedef struct {
    int          k;
    logic [31:0] mo;
    logic [31:0] sw;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   v_before, cs_falls, valid_at;
    logic p_cs;

    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      mo_word[i]   = '0;
      slv_word[i]  = '0;
      model_cnt[i] = 0;
      vcount[i]    = 0;
    end
    #3;
    check("rst_cs_n", cs_n, 3'b111);
    check("rst_sck", sck, 3'b000);
    check("rst_mosi", mosi_o, 3'b000);
    check("rst_valid", valid, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_rx0", rx0, 0);
    check("rst_rx1", rx1, 0);
    check("rst_rx2", rx2, 0);
`ifdef ADC_SPI_XFER_CNT_EN
    check("rst_xfer_cnt", xc2, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    vecs = '{
      '{0, 32'h0000_0000, 32'h00A5_C3F0},
      '{0, 32'h0080_0001, 32'h005A_5A5A},
      '{0, 32'h00FF_FFFF, 32'h0000_0000},
      '{1, 32'hD014_0000, 32'h1234_5678},
      '{1, 32'hFFFF_FFFF, 32'h8000_0001},
      '{2, 32'h0012_3456, 32'h00FE_DCBA}
    };
    for (int i = 0; i < 6; i++) do_xfer(vecs[i].k, vecs[i].mo, vecs[i].sw);

    for (int r = 0; r < 6; r++) do_xfer(r % 3, $urandom, $urandom);

    // Reset in the middle of a transfer on the default instance.
    do_xfer(0, 32'h0011_2233, 32'h00C0_FFEE);
    v_before    = vcount[0];
    mo_word[0]  = 32'h0055_AA55;
    slv_word[0] = 32'h0077_7777;
    @(negedge clk); start[0] = 1'b1;
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    start[0] = 1'b0;
    #1;
    check("async_rst_cs_n", cs_n[0], 1'b1);
    check("async_rst_sck", sck[0], 1'b0);
    check("async_rst_mosi", mosi_o[0], 1'b0);
    check("async_rst_busy", busy[0], 1'b0);
    check("async_rst_rx", rx0, 0);
    for (int i = 0; i < 3; i++) model_cnt[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    check("abort_no_valid", vcount[0], v_before);
    do_xfer(0, 32'h003C_3C3C, 32'h000F_1E2D);

    // Second rising edge at cycle 50, then start held high through cycle 200.
    v_before    = vcount[0];
    cs_falls    = 0;
    valid_at    = -1;
    p_cs        = 1'b1;
    mo_word[0]  = 32'h0080_0001;
    slv_word[0] = 32'h0013_579B;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (p_cs && !cs_n[0]) cs_falls++;
        if (valid[0] && valid_at < 0) valid_at = n;
      end
      p_cs     = cs_n[0];
      start[0] = (n < 10) || (n >= 50);
    end
    @(negedge clk); start[0] = 1'b0;
    check("busy_start_valid_count", vcount[0] - v_before, 1);
    check("busy_start_valid_cycle", valid_at, exp_lat(0));
    check("busy_start_cs_falls", cs_falls, 1);
    check("busy_start_rx", rx0, 32'h0013_579B);
    model_cnt[0]++;

    // Three back-to-back transfers on the CLK_DIV=1 instance.
    do_xfer(2, 32'h00AB_CDEF, 32'h0089_ABCD);
    do_xfer(2, 32'h0000_0001, 32'h0080_0000);
    do_xfer(2, 32'h00F0_F0F0, 32'h000F_0F0F);
`ifdef ADC_SPI_XFER_CNT_EN
    check("xfer_cnt_fast", xc2, model_cnt[2]);
    check("xfer_cnt_v", xc0, model_cnt[0]);
    check("xfer_cnt_dc", xc1, model_cnt[1]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
